// File: rtl/drum_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : drum_arbiter
// Description : Round-robin arbiter/sequencer sharing one DRUM approximate
//               signed (ones'-complement) multiplier among NREQ requesters.
//               Grant -> operand register -> product register -> response
//               channel with back-pressure.
//               Optional feature macro: DRUM_ARB_FASTPATH_EN (grant in the
//               same cycle as the response handshake, 1 product / 2 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module drum_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 8,
    parameter int K    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*N-1:0]          rsp_data
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_SW = $clog2(N) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [c_IW-1:0] r_last;
    logic [N-1:0]    r_op_a;
    logic [N-1:0]    r_op_b;
    logic [c_IW-1:0] r_op_id;

    logic            w_any;
    logic [c_IW-1:0] w_win;
    logic [c_IW-1:0] w_idx;
    logic            w_grant_ok;
    logic            w_grant;
    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;

    // Truncate one magnitude DRUM-style: returns {shift, K-bit fragment}.
    // Values with a leading one at or above bit K-1 keep the leading one plus
    // K-1 following bits, with the fragment LSB forced to 1 as the
    // unbiasing term; smaller values pass through exactly.
    function automatic logic [c_SW+K-1:0] f_trunc(input logic [N-1:0] m);
        logic [N-1:0]      sh;
        logic [c_SW-1:0]   s;
        logic              approx;
        logic [K-1:0]      t;
        sh     = m;
        s      = '0;
        approx = 1'b0;
        for (int i = K - 1; i < N; i++) begin
            if (m[i]) begin
                sh     = m >> (i - K + 1);
                s      = c_SW'(i - K + 1);
                approx = 1'b1;
            end
        end
        t = sh[K-1:0];
        if (approx) begin
            t[0] = 1'b1;
        end
        return {s, t};
    endfunction

    // Ones'-complement signed DRUM product of two N-bit operands.
    function automatic logic [2*N-1:0] f_drum(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0]      ma;
        logic [N-1:0]      mb;
        logic [c_SW+K-1:0] fa;
        logic [c_SW+K-1:0] fb;
        logic [2*N-1:0]    p;
        ma = a[N-1] ? ~a : a;
        mb = b[N-1] ? ~b : b;
        fa = f_trunc(ma);
        fb = f_trunc(mb);
        p  = (2*N)'(fa[K-1:0]) * (2*N)'(fb[K-1:0]);
        p  = p << fa[c_SW+K-1:K];
        p  = p << fb[c_SW+K-1:K];
        if (a[N-1] ^ b[N-1]) begin
            p = ~p;
        end
        return p;
    endfunction

    // Round-robin search starting just after the last winner, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = c_IW'((int'(r_last) + k) % NREQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

`ifdef DRUM_ARB_FASTPATH_EN
    assign w_grant_ok = (r_state == c_IDLE) || ((r_state == c_RESP) && rsp_ready);
`else
    assign w_grant_ok = (r_state == c_IDLE);
`endif

    // Reset gating keeps req_ready low while the block is held in reset.
    assign w_grant = rst_n && w_any && w_grant_ok;

    // One-hot grant and operand mux for the current winner.
    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_IW'(i)) begin
                w_sel_a = req_a[i*N +: N];
                w_sel_b = req_b[i*N +: N];
            end
        end
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Sequencer: IDLE (grant) -> MUL (product capture) -> RESP (handshake).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_last    <= c_IW'(NREQ - 1);
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_id   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_op_id <= w_win;
                        r_last  <= w_win;
                        r_state <= c_MUL;
                    end
                end
                c_MUL: begin
                    rsp_data  <= f_drum(r_op_a, r_op_b);
                    rsp_id    <= r_op_id;
                    rsp_valid <= 1'b1;
                    r_state   <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_grant) begin
                            r_op_a  <= w_sel_a;
                            r_op_b  <= w_sel_b;
                            r_op_id <= w_win;
                            r_last  <= w_win;
                            r_state <= c_MUL;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
